fc_cmd_arbiter: RTL
===================

FC_CMD_ARBITER -- requirements
Module: fc_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_L1A_SRC, default 4, number of L1A requesters (bit 0 sw, 1 calib, 2 timer, 3 external).
REQ-002 SHALL have parameter CNT_W, default 16, width of the vetoed-trigger counter.
REQ-003 SHALL have one clock and an asynchronous, active-high reset:
- clk_bx  in  1  bunch-crossing clock, the only clock.
- reset  in  1  asynchronous, active-high.
REQ-004 SHALL have the following ports:
- bx_zero  in  1  orbit start, from the bx counter.
- l1a_req  in  NUM_L1A_SRC  single-cycle L1A requests.
- link_reset_req  in  1  single-cycle request.
- buffer_clear_req  in  1  single-cycle request.
- calib_pulse_req  in  1  single-cycle request.
- calib_pulse_len  in  4  calib-pulse extension, in cycles.
- l1a_veto_len  in  12  minimum L1A spacing count.
- guard_len  in  8  L1A hold-off after a reset-type command.
- busy  in  1  DAQ/occupancy busy, already synchronised and enable-gated.
- enable  in  1  L1A enable.
- counters_clear  in  1  synchronous counter clear.
- fc_word  out  8  registered fast-control word.
- last_src  out  NUM_L1A_SRC  request bits that produced the last issued L1A.
- issued_count  out  32  count of L1As issued.
- vetoed_count  out  CNT_W  count of vetoed L1A request cycles.
- state  out  2  FSM state.

Function
REQ-005 SHALL register fc_word[0] from bx_zero with 1-cycle latency, independent of all arbitration.
REQ-006 SHALL treat any set bit of l1a_req in cycle N as one L1A request:
- If not vetoed, fc_word[1]=1 in cycle N+1.
- Simultaneous bits merge into one L1A.
- last_src captures l1a_req.
- issued_count increments by 1.
REQ-007 SHALL veto an L1A request when any of the following holds:
- spacing counter !=0;
- busy=1;
- state=GUARD;
- a reset-type command issues in the same cycle.
REQ-008 SHALL increment vetoed_count by 1 per vetoed request cycle, saturating at all-ones.
REQ-009 SHALL drop L1A requests while enable=0, without counting them as vetoed.
REQ-010 SHALL load the spacing counter with l1a_veto_len when an L1A is accepted and decrement it to 0, so the minimum fc_word[1] spacing is l1a_veto_len+1 cycles.
REQ-011 SHALL latch link_reset_req and buffer_clear_req into sticky pending flags. A request arriving in a given cycle SHALL count as pending in that same cycle.
REQ-012 SHALL implement the FSM with states IDLE=0 and GUARD=1.
REQ-013 SHALL, in IDLE with link_reset pending:
- set fc_word[2]=1 next cycle;
- clear the link_reset pending flag;
- load the guard counter with guard_len;
- go to GUARD.
REQ-014 SHALL, in IDLE with only buffer_clear pending, do the same as REQ-013 but with fc_word[3]. link_reset has priority over buffer_clear.
REQ-015 SHALL, in GUARD, decrement the guard counter and return to IDLE in the cycle after it reads 0. guard_len=0 therefore gives exactly one GUARD cycle.
REQ-016 SHALL keep requests that arrive during GUARD pending and issue them from the next IDLE cycle.
REQ-017 SHALL, on calib_pulse_req, load the calib extension counter with calib_pulse_len. fc_word[5] SHALL be registered as (calib_pulse_req OR calib extension counter !=0). Calib pulses are not arbitrated.
REQ-018 SHALL hold fc_word[4] and fc_word[7:6] at 0.
REQ-019 SHALL zero issued_count and vetoed_count one cycle after counters_clear. If counters_clear coincides with an increment, the clear SHALL win.
REQ-020 SHALL set at most one of fc_word[1], fc_word[2], fc_word[3] in any cycle.

Reset
REQ-021 SHALL, while reset is asserted, force the following to 0: fc_word, last_src, issued_count, vetoed_count, all pending flags and all counters.
REQ-022 SHALL force state to IDLE while reset is asserted.
REQ-023 SHALL discard any command pending or in GUARD when reset is asserted mid-operation, with no fc_word emission afterwards.

Structure
REQ-024 SHALL take fc_word bit indices (FC_BCR=0, FC_L1A=1, FC_LINK_RESET=2, FC_BUFFER_CLEAR=3, FC_CALIB=5) and the state encodings from shared package fc_pkg.
REQ-025 SHALL instantiate one generic loadable down-counter sub-module, fc_downcounter, three times: spacing, guard and calib extension.

Verification
REQ-026 SHALL verify spacing: l1a_veto_len=3; sw requests in cycles 10,12,14 -> fc_word[1] in cycles 11 and 15; vetoed_count=1.
REQ-027 SHALL verify merging: requests on bits 0 and 3 in the same cycle -> a single fc_word[1]; last_src=4'b1001; issued_count+1.
REQ-028 SHALL verify command priority: link_reset_req and buffer_clear_req in cycle 5 with guard_len=2 -> fc_word[2] at 6; GUARD cycles 6-8; fc_word[3] at 10.
REQ-029 SHALL verify collision: L1A and buffer_clear requested in the same IDLE cycle -> only fc_word[3] set; vetoed_count+1; an L1A requested during GUARD is vetoed.
REQ-030 SHALL verify busy and enable: busy=1 with 5 requests -> vetoed_count=5; enable=0 with 5 requests -> vetoed_count unchanged and no L1A.
REQ-031 SHALL verify reset mid-operation: assert reset during GUARD with buffer_clear pending -> state=IDLE, all outputs 0, no fc_word[3] after release.

Source files
------------

// File: rtl/fc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fc_pkg : shared fast-control bit indices and arbiter state encodings  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package fc_pkg;

    localparam int FC_BCR          = 0;
    localparam int FC_L1A          = 1;
    localparam int FC_LINK_RESET   = 2;
    localparam int FC_BUFFER_CLEAR = 3;
    localparam int FC_CALIB        = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1
    } fc_state_e;

endpackage
`default_nettype wire

// File: rtl/fc_downcounter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fc_downcounter : loadable down-counter that stops at zero             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fc_downcounter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             nonzero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign nonzero = (count != '0);

endmodule
`default_nettype wire

// File: rtl/fc_cmd_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fc_cmd_arbiter : merges L1A requests and reset-type commands into a   |
// | registered fast-control word.                         Rev 1.0         |
// +-----------------------------------------------------------------------+
module fc_cmd_arbiter
    import fc_pkg::*;
#(
    parameter int NUM_L1A_SRC = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_bx,
    input  logic                   reset,
    input  logic                   bx_zero,
    input  logic [NUM_L1A_SRC-1:0] l1a_req,
    input  logic                   link_reset_req,
    input  logic                   buffer_clear_req,
    input  logic                   calib_pulse_req,
    input  logic [3:0]             calib_pulse_len,
    input  logic [11:0]            l1a_veto_len,
    input  logic [7:0]             guard_len,
    input  logic                   busy,
    input  logic                   enable,
    input  logic                   counters_clear,
    output logic [7:0]             fc_word,
    output logic [NUM_L1A_SRC-1:0] last_src,
    output logic [31:0]            issued_count,
    output logic [CNT_W-1:0]       vetoed_count,
    output logic [1:0]             state
);

    fc_state_e cur_state;
    fc_state_e nxt_state;

    logic       link_pend;
    logic       buf_pend;
    logic       link_pend_now;
    logic       buf_pend_now;
    logic       issue_link;
    logic       issue_buf;
    logic       cmd_issue;
    logic       any_req;
    logic       l1a_veto;
    logic       l1a_accept;
    logic       l1a_vetoed;
    logic       spacing_nz;
    logic       guard_nz;
    logic       calib_nz;
    logic [7:0] fc_next;

    // A request arriving this cycle is already eligible to issue this cycle.
    assign link_pend_now = link_pend | link_reset_req;
    assign buf_pend_now  = buf_pend  | buffer_clear_req;

    assign issue_link = (cur_state == ST_IDLE) && link_pend_now;
    assign issue_buf  = (cur_state == ST_IDLE) && !link_pend_now && buf_pend_now;
    assign cmd_issue  = issue_link | issue_buf;

    assign any_req    = |l1a_req;
    assign l1a_veto   = spacing_nz | busy | (cur_state == ST_GUARD) | cmd_issue;
    assign l1a_accept = enable & any_req & ~l1a_veto;
    assign l1a_vetoed = enable & any_req &  l1a_veto;

    fc_downcounter #(.WIDTH(12)) u_spacing_cnt (
        .clk        (clk_bx),
        .rst        (reset),
        .load       (l1a_accept),
        .load_value (l1a_veto_len),
        .nonzero    (spacing_nz)
    );

    fc_downcounter #(.WIDTH(8)) u_guard_cnt (
        .clk        (clk_bx),
        .rst        (reset),
        .load       (cmd_issue),
        .load_value (guard_len),
        .nonzero    (guard_nz)
    );

    fc_downcounter #(.WIDTH(4)) u_calib_cnt (
        .clk        (clk_bx),
        .rst        (reset),
        .load       (calib_pulse_req),
        .load_value (calib_pulse_len),
        .nonzero    (calib_nz)
    );

    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            ST_IDLE:  if (cmd_issue) nxt_state = ST_GUARD;
            ST_GUARD: if (!guard_nz) nxt_state = ST_IDLE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        fc_next                  = '0;
        fc_next[FC_BCR]          = bx_zero;
        fc_next[FC_L1A]          = l1a_accept;
        fc_next[FC_LINK_RESET]   = issue_link;
        fc_next[FC_BUFFER_CLEAR] = issue_buf;
        fc_next[FC_CALIB]        = calib_pulse_req | calib_nz;
    end

    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            link_pend    <= 1'b0;
            buf_pend     <= 1'b0;
            fc_word      <= '0;
            last_src     <= '0;
            issued_count <= '0;
            vetoed_count <= '0;
        end else begin
            link_pend <= link_pend_now & ~issue_link;
            buf_pend  <= buf_pend_now  & ~issue_buf;
            fc_word   <= fc_next;
            if (l1a_accept) begin
                last_src <= l1a_req;
            end
            if (counters_clear) begin
                issued_count <= '0;
                vetoed_count <= '0;
            end else begin
                if (l1a_accept) begin
                    issued_count <= issued_count + 32'd1;
                end
                if (l1a_vetoed && (vetoed_count != '1)) begin
                    vetoed_count <= vetoed_count + CNT_W'(1);
                end
            end
        end
    end

    assign state = cur_state;

endmodule
`default_nettype wire
